// File: rtl/fir_decim_avg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_decim_avg
//  Purpose  : Decimating boxcar averager behind the pre-emphasis FIR. Every
//             N = 2^LOG2N qualified input samples are summed and divided by
//             N, rounding half toward +inf. Each result goes into a small
//             FIFO that is drained over a valid/ready handshake. A result
//             that arrives while the FIFO is full and not being popped is
//             dropped, and the sticky ovf flag is set.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1          rising-edge clock
//    rst      in   1          asynchronous reset, active low
//    en       in   1          x carries a valid FIR sample this cycle
//    x        in   DW         signed FIR sample (Q1.10 for DW=12)
//    y        out  DW         signed decimated sample at the FIFO head
//    y_valid  out  1          FIFO holds at least one sample
//    y_ready  in   1          consumer takes y this cycle
//    level    out  log2(D)+1  FIFO occupancy, 0..DEPTH
//    ovf      out  1          sticky: a decimated sample was dropped
//    clr_ovf  in   1          synchronous clear of ovf (a new drop wins)
// ============================================================================
module fir_decim_avg #(
  parameter int DW    = 12,
  parameter int LOG2N = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DW-1:0]            x,
  output logic [DW-1:0]            y,
  output logic                     y_valid,
  input  logic                     y_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     clr_ovf
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int LW   = PTRW + 1;

  // Asserted on the cycle that carries the last sample of a group; result
  // is the rounded average of that group, valid in the same cycle.
  logic          group_done;
  logic [DW-1:0] result;

  // --------------------------------------------------------------------------
  // Averaging front end
  // --------------------------------------------------------------------------
  generate
    if (LOG2N > 0) begin : g_avg
      localparam int AW = DW + LOG2N;
      // Half an LSB of the output, added before the shift so the arithmetic
      // shift rounds half toward +inf instead of truncating toward -inf.
      localparam logic signed [AW-1:0] HALF = AW'(1) <<< (LOG2N - 1);

      logic        [LOG2N-1:0] phase;
      logic signed [AW-1:0]    acc;
      logic signed [AW-1:0]    x_ext;
      logic signed [AW-1:0]    base;
      logic signed [AW-1:0]    sum;
      logic signed [AW-1:0]    rounded;
      logic                    unused_frac;

      assign x_ext = $signed({{LOG2N{x[DW-1]}}, x});

      // The first sample of a group starts from zero rather than the stale
      // accumulator, so the same adder serves both the load and accumulate
      // cases and also produces the completed group sum with the current x.
      assign base    = (phase == '0) ? '0 : acc;
      assign sum     = base + x_ext;
      assign rounded = sum + HALF;

      // Taking the top DW bits is the arithmetic shift by LOG2N. The sum of
      // N in-range samples plus HALF cannot leave AW bits, and the shifted
      // value always lands back inside the DW-bit range.
      assign result      = rounded[AW-1:LOG2N];
      assign unused_frac = ^rounded[LOG2N-1:0];

      // N is a power of two, so the last phase is all ones and the counter
      // wraps to zero by itself.
      assign group_done = en && (&phase);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          phase <= '0;
          acc   <= '0;
        end else if (en) begin
          phase <= phase + 1'b1;
          acc   <= sum;
        end
      end
    end else begin : g_pass
      // N = 1: every qualified sample is its own group.
      assign result     = x;
      assign group_done = en;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  logic [DW-1:0]   mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] rd_next;
  logic [LW-1:0]   count;
  logic            full;
  logic            pop;
  logic            push_ok;
  logic            drop;

  assign full    = (count == LW'(DEPTH));
  assign pop     = y_valid && y_ready;
  // A pop in the same cycle frees the slot the push needs, so a full FIFO
  // still accepts the result when the consumer is draining it.
  assign push_ok = group_done && (!full || pop);
  assign drop    = group_done && full && !pop;
  assign rd_next = rd_ptr + 1'b1;

  assign y_valid = (count != '0);
  assign level   = count;

  // Storage is never reset; count guards every read of it.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // y is a register that tracks the head entry. It only changes when the
  // head changes, so it keeps its last value once the FIFO drains and there
  // is no combinational path from y_ready to y.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y <= '0;
    end else if (pop) begin
      if (count > LW'(1)) begin
        // The next-oldest entry becomes head. A simultaneous push writes
        // the slot at wr_ptr, which is never rd_next while count > 1.
        y <= mem[rd_next];
      end else if (push_ok) begin
        // The only entry leaves and the new result becomes head.
        y <= result;
      end
    end else if ((count == '0) && push_ok) begin
      y <= result;
    end
  end

  // Sticky overflow flag; a drop in the same cycle beats the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_avg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_decim_avg
//  Purpose  : Self-checking bench for fir_decim_avg (DW=12, LOG2N=2,
//             DEPTH=4). Inputs change on the falling edge and outputs are
//             compared on the following falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_decim_avg;

  localparam int DW    = 12;
  localparam int LOG2N = 2;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                 clk     = 1'b0;
  logic                 rst     = 1'b1;
  logic                 en      = 1'b0;
  logic [DW-1:0]        x       = '0;
  logic [DW-1:0]        y;
  logic                 y_valid;
  logic                 y_ready = 1'b0;
  logic [LW-1:0]        level;
  logic                 ovf;
  logic                 clr_ovf = 1'b0;

  fir_decim_avg #(
    .DW    (DW),
    .LOG2N (LOG2N),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .x       (x),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .level   (level),
    .ovf     (ovf),
    .clr_ovf (clr_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // One clock of stimulus plus the outputs expected after that edge.
  typedef struct {
    logic en;
    int   x;
    logic rdy;
    logic clr;
    logic ev;   // expected y_valid; y is only compared when this is 1
    int   ey;
    int   el;
    logic eo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ys();
    return int'($signed(y));
  endfunction

  // Drive one cycle from a falling edge and return on the next falling edge.
  task automatic cyc(input logic e, input int xv, input logic r, input logic c);
    en      = e;
    x       = xv[DW-1:0];
    y_ready = r;
    clr_ovf = c;
    @(negedge clk);
  endtask

  // Reset is asserted between edges to show it acts without a clock.
  task automatic do_reset(input string tag);
    en      = 1'b0;
    y_ready = 1'b0;
    clr_ovf = 1'b0;
    rst     = 1'b0;
    #1;
    chk({tag, ".rst_y"},     ys(),        0);
    chk({tag, ".rst_valid"}, int'(y_valid), 0);
    chk({tag, ".rst_level"}, int'(level),   0);
    chk({tag, ".rst_ovf"},   int'(ovf),     0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Four samples with y_ready=1 throughout: the previous result is popped
  // on the first sample, and the new one appears after the fourth.
  task automatic add_group(input int a, input int b, input int c, input int d,
                           input int e);
    vecs.push_back('{1'b1, a, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0});
    vecs.push_back('{1'b1, b, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0});
    vecs.push_back('{1'b1, c, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0});
    vecs.push_back('{1'b1, d, 1'b1, 1'b0, 1'b1, e, 1, 1'b0});
  endtask

  initial begin
    int bp_exp[4];
    int fl_exp[4];

    // ---------------- table-driven: impulse, rounding, extremes ----------
    add_group(1024, 0, 0, 0, 256);         // 1.0 impulse -> 0x100
    add_group(0, 0, 0, 0, 0);
    add_group(0, 0, 0, 0, 0);
    add_group(1, 1, 1, 2, 1);              // (5+2)>>2
    add_group(-1, -1, -1, -2, -1);         // (-5+2)>>>2
    add_group(0, 0, 0, 2, 1);              // (2+2)>>2, half rounds up
    add_group(0, 0, 0, -2, 0);             // (-2+2)>>2, half rounds up
    add_group(2047, 2047, 2047, 2047, 2047);
    add_group(-2048, -2048, -2048, -2048, -2048);
    vecs.push_back('{1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0});

    #2;
    do_reset("init");

    foreach (vecs[i]) begin
      cyc(vecs[i].en, vecs[i].x, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("vec%0d.valid", i), int'(y_valid), int'(vecs[i].ev));
      chk($sformatf("vec%0d.level", i), int'(level),   vecs[i].el);
      chk($sformatf("vec%0d.ovf", i),   int'(ovf),     int'(vecs[i].eo));
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d.y", i), ys(), vecs[i].ey);
      end
    end

    // ---------------- back-pressure and overflow ------------------------
    // Groups of 4k: sums 40,104,168,232 -> rounded averages 10,26,42,58.
    do_reset("bp");
    bp_exp = '{10, 26, 42, 58};
    for (int k = 1; k <= 24; k++) begin
      cyc(1'b1, 4 * k, 1'b0, 1'b0);
      if (k == 16) begin
        chk("bp.level_full", int'(level), 4);
        chk("bp.ovf_before", int'(ovf),   0);
      end
      if (k == 19) chk("bp.ovf_mid_group", int'(ovf), 0);
      if (k == 20) chk("bp.ovf_5th", int'(ovf), 1);
    end
    chk("bp.level_after", int'(level), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp.valid%0d", i), int'(y_valid), 1);
      chk($sformatf("bp.y%0d", i),     ys(),           bp_exp[i]);
      cyc(1'b0, 0, 1'b1, 1'b0);
    end
    chk("bp.drained_level", int'(level),   0);
    chk("bp.drained_valid", int'(y_valid), 0);
    chk("bp.y_hold",        ys(),          58);
    chk("bp.ovf_sticky",    int'(ovf),     1);
    cyc(1'b0, 0, 1'b0, 1'b1);
    chk("bp.ovf_cleared",   int'(ovf),     0);

    // ---------------- full FIFO with simultaneous push and pop ----------
    for (int k = 0; k < 16; k++) cyc(1'b1, 8, 1'b0, 1'b0);
    chk("full.level", int'(level), 4);
    for (int k = 0; k < 4; k++) cyc(1'b1, 20, (k == 3), 1'b0);
    chk("full.pp_level", int'(level), 4);
    chk("full.pp_ovf",   int'(ovf),   0);
    fl_exp = '{8, 8, 8, 20};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full.y%0d", i), ys(), fl_exp[i]);
      cyc(1'b0, 0, 1'b1, 1'b0);
    end
    chk("full.drained", int'(level), 0);

    // Drop and clear in the same cycle: the drop wins.
    for (int k = 0; k < 16; k++) cyc(1'b1, 8, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, 20, 1'b0, (k == 3));
    chk("clr.set_wins",  int'(ovf),   1);
    chk("clr.level",     int'(level), 4);
    cyc(1'b0, 0, 1'b0, 1'b1);
    chk("clr.cleared",   int'(ovf),   0);

    // ---------------- en gaps ------------------------------------------
    do_reset("gap");
    cyc(1'b1, 100, 1'b0, 1'b0);
    cyc(1'b1, 100, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 0, 1'b0, 1'b0);
    chk("gap.idle_level", int'(level), 0);
    cyc(1'b1, 100, 1'b0, 1'b0);
    cyc(1'b1, 100, 1'b0, 1'b0);
    chk("gap.level", int'(level),   1);
    chk("gap.valid", int'(y_valid), 1);
    chk("gap.y",     ys(),          100);

    // ---------------- reset mid-group ----------------------------------
    do_reset("mid0");
    cyc(1'b1, 100, 1'b0, 1'b0);
    cyc(1'b1, 100, 1'b0, 1'b0);
    do_reset("mid1");
    cyc(1'b1, 0, 1'b0, 1'b0);
    cyc(1'b1, 0, 1'b0, 1'b0);
    chk("mid.half_level", int'(level), 0);
    cyc(1'b1, 0, 1'b0, 1'b0);
    cyc(1'b1, 0, 1'b0, 1'b0);
    chk("mid.level", int'(level),   1);
    chk("mid.valid", int'(y_valid), 1);
    chk("mid.y",     ys(),          0);
    chk("mid.ovf",   int'(ovf),     0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
